// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter (RTS, 11-bit frame, ack).
// Define PS2_TX_TIMEOUT_EN to add a watchdog on device clock edges.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  // One counter serves both the RTS inhibit and the watchdog.
  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
    TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RTS       = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    filt_q, filt_d;
  logic          fclk_q, fclk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bits_q, bits_d;
  logic [8:0]    sh_q, sh_d;
  logic          nack_q, nack_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          idle_q, idle_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fall_edge;

  always_comb begin
    filt_d = {ps2_clk_in, filt_q[7:1]};
    fclk_d = fclk_q;
    if (filt_q == 8'hff)
      fclk_d = 1'b1;
    else if (filt_q == 8'h00)
      fclk_d = 1'b0;
  end

  assign fall_edge = fclk_q & ~fclk_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          sh_d    = {~^din, din};
          cnt_d   = '0;
          nack_d  = 1'b0;
          state_d = RTS;
        end
      end
      RTS: begin
        if (cnt_q == INH_LAST)
          state_d = START;
        else
          cnt_d = cnt_q + CW'(1);
      end
      START: begin
        if (fall_edge) begin
          bits_d  = 4'd8;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall_edge) begin
          if (bits_q == 4'd0) begin
            state_d = STOP;
          end else begin
            sh_d   = {1'b0, sh_q[8:1]};
            bits_d = bits_q - 4'd1;
          end
        end
      end
      STOP: begin
        if (fall_edge) begin
          nack_d  = ps2_data_in;
          err_d   = ps2_data_in;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (fclk_q && ps2_data_in) begin
          done_d  = ~nack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (state_d inside {START, DATA, STOP, WAIT_IDLE}) begin
      if (state_d != state_q || fall_edge)
        cnt_d = '0;
      else
        cnt_d = cnt_q + CW'(1);
    end
    if ((state_q inside {START, DATA, STOP, WAIT_IDLE})
        && cnt_q == TO_LAST) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
`endif
    // Outputs follow the next state so they line up with state_q.
    clk_oe_d  = (state_d == RTS);
    data_oe_d = (state_d == RTS && cnt_d == INH_LAST)
              || (state_d == START)
              || (state_d == DATA && !sh_d[0]);
    idle_d    = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      filt_q    <= '0;
      fclk_q    <= 1'b0;
      cnt_q     <= '0;
      bits_q    <= '0;
      sh_q      <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      fclk_q    <= fclk_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      sh_q      <= sh_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx_idle      = idle_q;
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed frames against a PS/2 device model on
// wired-AND clock/data lines.
module tb_ps2_tx;

  localparam int INH = 5000;
  localparam int HI  = 20;
  localparam int LO  = 20;
  // 8 filter cycles plus 1 edge register, then 100 idle cycles.
  localparam int TO_LAT = 109;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_idle, tx_done_tick, tx_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err(tx_err)
  );

  always @(posedge clk) begin
    if (tx_done_tick) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done_tick && tx_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] d);
    int n;
    int nd;
    logic last;
    n = 0;
    nd = 0;
    last = 1'b0;
    check("idle_before_wr", tx_idle, 1);
    pulse_wr(d);
    while (ps2_clk_oe && n < 2 * INH) begin
      n++;
      if (ps2_data_oe) nd++;
      last = ps2_data_oe;
      @(negedge clk);
    end
    check("rts_cycles", n, INH);
    check("rts_data_cycles", nd, 1);
    check("rts_data_last", last, 1);
  endtask

  task automatic dev_edge(input int k, input logic lvl,
                          input logic ack);
    repeat (HI) @(negedge clk);
    check($sformatf("line_before_edge%0d", k), ps2_data_in, lvl);
    dev_clk = 1'b0;
    if (k == 11) dev_data = ack;
    repeat (LO) @(negedge clk);
    dev_clk = 1'b1;
    if (k == 11) dev_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par,
                           input logic ack, input logic inj);
    logic [10:0] lvl;
    int d0;
    int e0;
    lvl = {1'b1, par, d, 1'b0};
    d0 = done_cnt;
    e0 = err_cnt;
    send_wr(d);
    for (int k = 1; k <= 11; k++) begin
      dev_edge(k, lvl[k-1], ack);
      if (inj && k == 4) begin
        pulse_wr(8'hFF);
        check("busy_after_inject", tx_idle, 0);
      end
    end
    repeat (40) @(negedge clk);
    check("done_pulses", done_cnt - d0, ack ? 0 : 1);
    check("err_pulses", err_cnt - e0, ack ? 1 : 0);
    check("idle_after", tx_idle, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int d0;
    int e0;
    int n;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    run_frame(8'h55, 1'b1, 1'b0, 1'b0);
    run_frame(8'hED, 1'b1, 1'b0, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    run_frame(8'h96, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a frame while data is driven low.
    send_wr(8'h00);
    for (int k = 1; k <= 4; k++)
      dev_edge(k, 1'b0, 1'b0);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_idle", tx_idle, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_done", done_cnt - d0, 0);
    check("midrst_err", err_cnt - e0, 0);
    check("midrst_idle_after", tx_idle, 1);

    // Device stops clocking after edge 3.
    send_wr(8'h55);
    dev_edge(1, 1'b0, 1'b0);
    dev_edge(2, 1'b1, 1'b0);
    repeat (HI) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_clk = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n == LO) dev_clk = 1'b1;
      if (tx_err) seen = 1'b1;
    end
`ifdef PS2_TX_TIMEOUT_EN
    check("to_latency", n, TO_LAT);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_idle", tx_idle, 1);
    repeat (20) @(negedge clk);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_done_pulses", done_cnt - d0, 0);
`else
    check("no_to_err", seen, 0);
    check("no_to_busy", tx_idle, 0);
    check("no_to_done", done_cnt - d0, 0);
`endif
    do_reset();
    check("final_idle", tx_idle, 1);
    check("done_err_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
